microsequencer: RTL
===================

// Module: microsequencer
// PURPOSE
//  Registered micro-PC sequencer for the microprogrammed control unit. Each cycle selects the next control-store address:
//  explicit, incremented, conditional branch, dispatch on opcode/funct, or call/return via a micro-subroutine stack.
//  Latches op/funct at dispatch with a valid/ready handshake. Drives the control-store address; the store feeds back seq_op/next_adr.
// PARAMETERS
//  ADDR_W       5   micro-address width; must be >= 5 (elaboration assertion)
//  OP_W         2   opcode field width
//  FUNCT_W      6   funct field width; must be >= 6
//  STACK_DEPTH  4   return-stack entries; must be >= 1
//  RESET_ADR    0   upc value after reset
// PORTS
//  clk          in   1        clock, rising edge
//  reset_n      in   1        asynchronous active-low reset
//  stall        in   1        1 = hold all state this cycle
//  seq_op       in   3        sequencing op from current microinstruction
//  next_adr     in   ADDR_W   target address field from current microinstruction
//  cond         in   1        branch condition for SEQ_BRANCH
//  instr_valid  in   1        op/funct valid from fetch path
//  op           in   OP_W     instruction opcode
//  funct        in   FUNCT_W  instruction funct
//  instr_ready  out  1        one-cycle pulse: op/funct consumed this cycle
//  upc          out  ADDR_W   registered micro-PC (control-store address)
//  sp           out  $clog2(STACK_DEPTH+1)  stack occupancy
//  err          out  1        sticky stack error (0 when MSEQ_STACK_ERR_EN undefined)
// BEHAVIOUR
//  Reset (async, reset_n=0): upc=RESET_ADR, sp=0, err=0, latched op/funct=0, instr_ready=0.
//  Latency: seq_op/next_adr/cond/op/funct are combinational inputs; upc updates on the next edge. stall=1 freezes upc, sp, stack, latches; instr_ready=0.
//  seq_op: 000 NEXT  upc<=next_adr | 001 INC  upc<=upc+1 (wraps mod 2^ADDR_W) | 100 BRANCH  cond ? next_adr : upc+1
//   010 DISP1  if instr_valid: latch op/funct, instr_ready=1 (combinational, same cycle), upc<=disp1(op,funct); else hold upc, instr_ready=0
//   011 DISP2  upc<=disp2(latched funct) | 101 CALL  push upc+1, upc<=next_adr | 110 RET  upc<=pop | 111 FETCH  upc<=RESET_ADR
//  disp1: op=01->2; op=10->9; else funct[5]=1 (EI)/0 (ER) with funct[4:1]: 0100->7/6; 0010|1010->13/10; 0000->14/11; other->15/12.
//  disp2: latched funct[0]=1 -> 3, else 5. Constants zero-extended to ADDR_W.
//  instr_ready asserts only on a non-stalled DISP1 with instr_valid=1; never otherwise.
//  Stack: LIFO, sp counts 0..STACK_DEPTH. CALL when full / RET when empty are boundary cases (see CONFIGURATION).
//  Unused seq_op codes: none; all 8 are defined.
// CONFIGURATION
//  MSEQ_STACK_ERR_EN defined: CALL on full -> no push, err<=1, upc<=next_adr; RET on empty -> err<=1, upc<=RESET_ADR, sp stays 0.
//   err is sticky, cleared only by reset.
//  Undefined: CALL on full overwrites oldest entry (circular), sp stays STACK_DEPTH; RET on empty returns RESET_ADR, sp stays 0; err tied 0.
// STRUCTURE
//  microseq_pkg: seq_op_e enum (SEQ_NEXT..SEQ_FETCH), dispatch address localparams, functions disp1()/disp2().
//  Sub-module microseq_stack (LIFO, parameters ADDR_W/STACK_DEPTH, push/pop/full/empty/sp, circular-overwrite mode input).
//  Top: upc register, op/funct latch, next-address mux, handshake and error logic.
// TESTING
//  Reset mid-run: upc=9, sp=2, drop reset_n asynchronously -> upc=0, sp=0, err=0 before next edge.
//  DISP1 handshake: instr_valid=0 two cycles -> upc held, instr_ready=0; then valid, op=00, funct=6'b101000 -> instr_ready=1, upc=7 next edge.
//  DISP2 on latched funct: after DISP1 with funct=6'b000101, change funct input to 0, issue DISP2 -> upc=3.
//  Call/return: upc=4, CALL next_adr=20 -> upc=20, sp=1; RET -> upc=5, sp=0.
//  Stack overflow (STACK_DEPTH=4): five CALLs -> with MSEQ_STACK_ERR_EN err=1, sp=4; without, err=0 and four RETs return last four pushes.
//  Stall/wrap: upc=31, INC with stall=1 -> upc=31; stall=0 -> upc=0; BRANCH cond=0 from 3 -> 4, cond=1 next_adr=12 -> 12.

Source files
------------

// File: rtl/microseq_pkg.sv
// microseq_pkg: sequencing op encoding and opcode/funct dispatch address tables for the microsequencer
package microseq_pkg;
  typedef enum logic [2:0] {
    SEQ_NEXT   = 3'b000,
    SEQ_INC    = 3'b001,
    SEQ_DISP1  = 3'b010,
    SEQ_DISP2  = 3'b011,
    SEQ_BRANCH = 3'b100,
    SEQ_CALL   = 3'b101,
    SEQ_RET    = 3'b110,
    SEQ_FETCH  = 3'b111
  } seq_op_e;
  localparam logic [4:0] ADR_OP1 = 5'd2;
  localparam logic [4:0] ADR_OP2 = 5'd9;
  localparam logic [4:0] ADR_D2_ODD = 5'd3;
  localparam logic [4:0] ADR_D2_EVEN = 5'd5;
  // funct[4:1] class rows: 0100, x010, 0000, other; EI when funct[5]=1, ER otherwise
  localparam logic [3:0][4:0] ADR_EI = {5'd15, 5'd14, 5'd13, 5'd7};
  localparam logic [3:0][4:0] ADR_ER = {5'd12, 5'd11, 5'd10, 5'd6};
  function automatic logic [4:0] disp1(input logic is_op1, input logic is_op2, input logic [5:0] f);
    logic [1:0] row;
    row = (f[4:1] == 4'b0100) ? 2'd0 : (f[4:1] ==? 4'b?010) ? 2'd1 : (f[4:1] == 4'b0000) ? 2'd2 : 2'd3;
    return is_op1 ? ADR_OP1 : is_op2 ? ADR_OP2 : f[5] ? ADR_EI[row] : ADR_ER[row];
  endfunction
  function automatic logic [4:0] disp2(input logic f0);
    return f0 ? ADR_D2_ODD : ADR_D2_EVEN;
  endfunction
endpackage

// File: rtl/microseq_stack.sv
// microseq_stack: shift-register LIFO of return addresses for micro-subroutine calls
// Ports: clk, reset_n (async active-low), i_push/i_pop/i_wdata (push/pop request and data),
//        i_circ (1 = push on full drops the oldest entry, 0 = push on full is ignored),
//        o_rdata (top entry), o_full, o_empty, o_sp (occupancy 0..STACK_DEPTH)
module microseq_stack #(
  parameter int ADDR_W = 5,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               i_push,
  input  logic                               i_pop,
  input  logic                               i_circ,
  input  logic [ADDR_W-1:0]                  i_wdata,
  output logic [ADDR_W-1:0]                  o_rdata,
  output logic                               o_full,
  output logic                               o_empty,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   o_sp
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
  logic [SP_W-1:0] r_sp;
  logic w_push, w_pop;
  assign o_full = r_sp == SP_W'(STACK_DEPTH);
  assign o_empty = r_sp == '0;
  assign w_push = i_push && (!o_full || i_circ);
  assign w_pop = i_pop && !o_empty;
  assign o_rdata = r_mem[0];
  assign o_sp = r_sp;
  // entry 0 is the top; a push shifts everything down so the oldest entry falls off the end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[0] <= i_wdata;
      for (int i = 1; i < STACK_DEPTH; i++) r_mem[i] <= r_mem[i-1];
      if (!o_full) r_sp <= r_sp + SP_W'(1);
    end else if (w_pop) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      r_sp <= r_sp - SP_W'(1);
    end
endmodule

// File: rtl/microsequencer.sv
// microsequencer: registered micro-PC sequencer with dispatch, branch and call/return stack
// Ports: clk, reset_n (async active-low), stall (freeze all state), seq_op/next_adr/cond (from microinstruction),
//        instr_valid/op/funct (fetch path), instr_ready (op/funct consumed this cycle),
//        upc (control-store address), sp (stack occupancy), err (sticky stack error)
// Build option: MSEQ_STACK_ERR_EN enables stack overflow/underflow error reporting; otherwise
//        CALL on full overwrites the oldest entry and err is tied low.
module microsequencer
  import microseq_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int OP_W = 2,
  parameter int FUNCT_W = 6,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADR = 0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               stall,
  input  logic [2:0]                         seq_op,
  input  logic [ADDR_W-1:0]                  next_adr,
  input  logic                               cond,
  input  logic                               instr_valid,
  input  logic [OP_W-1:0]                    op,
  input  logic [FUNCT_W-1:0]                 funct,
  output logic                               instr_ready,
  output logic [ADDR_W-1:0]                  upc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               err
);
  if (ADDR_W < 5) begin : g_bad_addr_w
    $error("microsequencer: ADDR_W must be >= 5");
  end
  if (FUNCT_W < 6) begin : g_bad_funct_w
    $error("microsequencer: FUNCT_W must be >= 6");
  end
  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("microsequencer: STACK_DEPTH must be >= 1");
  end
  localparam logic [ADDR_W-1:0] RST_ADR = ADDR_W'(RESET_ADR);
  logic [ADDR_W-1:0] r_upc, w_upc_nxt, w_inc, w_top;
  logic [OP_W-1:0] r_op;
  logic [FUNCT_W-1:0] r_funct;
  logic r_err;
  seq_op_e w_op;
  logic w_disp, w_push, w_pop, w_full, w_empty, w_circ, w_err_set, w_is_op1, w_is_op2;
  logic w_unused;
  assign w_op = seq_op_e'(seq_op);
  assign w_inc = r_upc + ADDR_W'(1);
  assign w_is_op1 = 32'(op) == 32'd1;
  assign w_is_op2 = 32'(op) == 32'd2;
  assign w_disp = !stall && w_op == SEQ_DISP1 && instr_valid;
  assign w_push = !stall && w_op == SEQ_CALL;
  assign w_pop = !stall && w_op == SEQ_RET;
  // the latched op and upper funct bits are kept for the control unit but not needed by disp2
  assign w_unused = ^{r_op, r_funct[FUNCT_W-1:1], w_full};
`ifdef MSEQ_STACK_ERR_EN
  assign w_circ = 1'b0;
  assign w_err_set = (w_push && w_full) || (w_pop && w_empty);
`else
  assign w_circ = 1'b1;
  assign w_err_set = 1'b0;
`endif
  assign instr_ready = reset_n && w_disp;
  assign upc = r_upc;
  assign err = r_err;
  microseq_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_circ  (w_circ),
    .i_wdata (w_inc),
    .o_rdata (w_top),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_sp    (sp)
  );
  always_comb begin
    w_upc_nxt = r_upc;
    case (w_op)
      SEQ_NEXT:   w_upc_nxt = next_adr;
      SEQ_INC:    w_upc_nxt = w_inc;
      SEQ_DISP1:  w_upc_nxt = instr_valid ? ADDR_W'(disp1(w_is_op1, w_is_op2, funct[5:0])) : r_upc;
      SEQ_DISP2:  w_upc_nxt = ADDR_W'(disp2(r_funct[0]));
      SEQ_BRANCH: w_upc_nxt = cond ? next_adr : w_inc;
      SEQ_CALL:   w_upc_nxt = next_adr;
      SEQ_RET:    w_upc_nxt = w_empty ? RST_ADR : w_top;
      SEQ_FETCH:  w_upc_nxt = RST_ADR;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_upc <= RST_ADR;
      r_op <= '0;
      r_funct <= '0;
      r_err <= 1'b0;
    end else if (!stall) begin
      r_upc <= w_upc_nxt;
      r_err <= r_err | w_err_set;
      if (w_disp) begin
        r_op <= op;
        r_funct <= funct;
      end
    end
endmodule
